// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_FAULT
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ALIGN   = 2'b01,
    CAUSE_BUS     = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } lsu_cause_e;

  // RV32I funct3 width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: enables, write replication, read extraction and
// the legality/alignment check for one access.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bad
);

  logic        legal;
  logic        misaligned;
  logic [31:0] shifted;

  // Decode width from funct3[1:0] and steer data into/out of the lanes.
  always_comb begin
    if (is_store) begin
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end

    shifted = mem_rdata >> {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        rdata      = {24'h0, shifted[7:0]};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        rdata      = {16'h0, shifted[15:0]};
      end
      2'b10: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata      = store_data;
        rdata      = shifted;
      end
      default: begin
        misaligned = 1'b0;
        be         = '0;
        wdata      = '0;
        rdata      = '0;
      end
    endcase

    bad = !legal || misaligned;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a
// simple req/ack memory port, with alignment checks and a wait timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  lsu_cause_e  cause_q;
  logic [31:0] addr_q, data_q, load_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [CW-1:0] wait_q;

  logic        in_idle, accept, timeout_hit;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic        al_st;
  logic [31:0] al_data;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_bad;

  assign in_idle     = (state_q == ST_IDLE);
  assign accept      = in_idle && start && (is_load ^ is_store);
  assign timeout_hit = (wait_q == CW'(TIMEOUT_CYCLES - 1));

  // The aligner checks the live request while idle and steers the
  // latched request once it is in flight, so one instance serves both.
  assign al_f3   = in_idle ? funct3     : f3_q;
  assign al_lo   = in_idle ? addr[1:0]  : addr_q[1:0];
  assign al_st   = in_idle ? is_store   : we_q;
  assign al_data = in_idle ? store_data : data_q;

  lsu_lane_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .is_store   (al_st),
    .store_data (al_data),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .rdata      (al_rdata),
    .bad        (al_bad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = al_bad ? ST_FAULT : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ack)          state_d = mem_err ? ST_FAULT : ST_RESP;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, fault cause and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      load_q  <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      data_q  <= store_data;
      f3_q    <= funct3;
      we_q    <= is_store;
      wait_q  <= '0;
      cause_q <= al_bad ? CAUSE_ALIGN : CAUSE_NONE;
    end else if (state_q == ST_ACCESS) begin
      if (mem_ack) begin
        if (mem_err)    cause_q <= CAUSE_BUS;
        else if (!we_q) load_q  <= al_rdata;
      end else begin
        if (timeout_hit) cause_q <= CAUSE_TIMEOUT;
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  // Moore outputs; bus fields are driven only while a request is on the port.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_RESP) || (state_q == ST_FAULT);
    fault       = (state_q == ST_FAULT);
    fault_cause = (state_q == ST_FAULT) ? cause_q : CAUSE_NONE;
    load_data   = load_q;
    mem_req     = (state_q == ST_ACCESS);
    mem_we      = '0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    if (state_q == ST_ACCESS) begin
      mem_we    = we_q;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_be    = al_be;
      mem_wdata = al_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk, rst, start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_be;
  logic        mem_ack, mem_err;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_load     (is_load),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  logic        e_busy, e_done, e_fault, e_req, e_we;
  logic [1:0]  e_cause;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;
  logic [31:0] m_ld;

  // Hand-computed literal expectations: 0 mem_addr, 1 mem_be, 2 mem_wdata,
  // 3 load_data, 4 fault_cause, 5 done, 6 mem_req.
  bit   [6:0]  pin_en;
  logic [31:0] pin_val [7];
  int          pin_cyc;
  bit   [6:0]  pin_cfg_en;
  logic [31:0] pin_cfg_val [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pin_act(input int i);
    case (i)
      0: return mem_addr;
      1: return {28'h0, mem_be};
      2: return mem_wdata;
      3: return load_data;
      4: return {30'h0, fault_cause};
      5: return {31'h0, done};
      default: return {31'h0, mem_req};
    endcase
  endfunction

  function automatic string pin_name(input int i);
    case (i)
      0: return "lit_mem_addr";
      1: return "lit_mem_be";
      2: return "lit_mem_wdata";
      3: return "lit_load_data";
      4: return "lit_fault_cause";
      5: return "lit_done";
      default: return "lit_mem_req";
    endcase
  endfunction

  // Compare process: checks DUT outputs mid-cycle against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'h0, busy}, {31'h0, e_busy});
      chk("done", {31'h0, done}, {31'h0, e_done});
      chk("fault", {31'h0, fault}, {31'h0, e_fault});
      chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
      chk("load_data", load_data, e_ld);
      if (e_done) chk("fault_cause", {30'h0, fault_cause}, {30'h0, e_cause});
      if (e_req) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, e_be});
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      for (int i = 0; i < 7; i++)
        if (pin_en[i]) chk(pin_name(i), pin_act(i), pin_val[i]);
    end
  end

  // Model of the access rules in terms of byte counts and lane positions.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_ok(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int n;
    legal = ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    n = nbytes(f3);
    return legal && ((a % n) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] r;
    int lo, n;
    lo = int'(a % 4);
    n  = nbytes(f3);
    for (int i = 0; i < 4; i++) r[i] = (i >= lo) && (i < lo + n);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ldata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] r;
    int lo, n;
    lo = int'(a % 4);
    n  = nbytes(f3);
    r  = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rd[8*(lo + i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start   = 1'b0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
  endtask

  task automatic garble();
    start      = 1'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
  endtask

  task automatic set_exp_idle();
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_fault = 1'b0;
    e_req   = 1'b0;
    e_we    = 1'b0;
    e_cause = 2'b00;
    e_ld    = m_ld;
  endtask

  task automatic apply_pins(input int c);
    if (c == pin_cyc) begin
      pin_en = pin_cfg_en;
      for (int i = 0; i < 7; i++) pin_val[i] = pin_cfg_val[i];
    end else begin
      pin_en = '0;
    end
  endtask

  task automatic pin(input int cyc, input int idx, input logic [31:0] v);
    pin_cyc          = cyc;
    pin_cfg_en[idx]  = 1'b1;
    pin_cfg_val[idx] = v;
  endtask

  task automatic pins_clear();
    pin_cyc    = -1;
    pin_cfg_en = '0;
  endtask

  // One transaction: start in cycle 0, ack in cycle k (0 = never),
  // optional reset asserted in ACCESS cycle rc (0 = none).
  task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int k,
                        input bit err, input int rc);
    bit fin;
    tick();
    quiet();
    start = 1'b1; is_load = ld; is_store = !ld;
    funct3 = f3; addr = a; store_data = d;
    set_exp_idle();
    apply_pins(0);
    if (!op_ok(ld, f3, a)) begin
      tick();
      garble();
      set_exp_idle();
      e_busy = 1'b1; e_done = 1'b1; e_fault = 1'b1; e_cause = 2'b01;
      apply_pins(1);
      tick();
      quiet();
      set_exp_idle();
      apply_pins(2);
    end else begin
      fin = 1'b0;
      for (int c = 1; c <= TMO && !fin; c++) begin
        tick();
        garble();
        mem_ack   = (c == k);
        mem_err   = (c == k) ? err : 1'($urandom);
        mem_rdata = (c == k) ? rd : $urandom;
        rst       = (c == rc);
        set_exp_idle();
        e_busy = 1'b1; e_req = 1'b1; e_we = !ld;
        e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wdata = m_wdata(f3, d);
        apply_pins(c);
        if (c == rc) begin
          tick();
          quiet();
          rst = 1'b0;
          mem_ack = 1'b1;
          m_ld = '0;
          set_exp_idle();
          apply_pins(c + 1);
          tick();
          quiet();
          set_exp_idle();
          apply_pins(c + 2);
          fin = 1'b1;
        end else if (c == k) begin
          tick();
          garble();
          mem_ack = 1'b0;
          if (!err && ld) m_ld = m_ldata(f3, a, rd);
          set_exp_idle();
          e_busy = 1'b1; e_done = 1'b1;
          e_fault = err; e_cause = err ? 2'b10 : 2'b00;
          apply_pins(c + 1);
          tick();
          quiet();
          set_exp_idle();
          apply_pins(c + 2);
          fin = 1'b1;
        end
      end
      if (!fin) begin
        tick();
        garble();
        mem_ack = 1'b0;
        set_exp_idle();
        e_busy = 1'b1; e_done = 1'b1; e_fault = 1'b1; e_cause = 2'b11;
        apply_pins(TMO + 1);
        tick();
        quiet();
        set_exp_idle();
        apply_pins(TMO + 2);
      end
    end
    pins_clear();
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; mem_rdata = '0;
    m_ld = '0;
    pin_en = '0;
    pins_clear();
    for (int i = 0; i < 7; i++) begin pin_val[i] = '0; pin_cfg_val[i] = '0; end

    // Reset values.
    tick();
    tick();
    set_exp_idle();
    pin_en = 7'b0011111;
    for (int i = 0; i < 7; i++) pin_val[i] = '0;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    pin_en = '0;
    set_exp_idle();

    // SB to 0x1003, ack in cycle 1.
    pin(1, 0, 32'h0000_1000); pin(1, 1, 32'h8); pin(1, 2, 32'hA5A5_A5A5);
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, 1'b0, 0);

    // LHU from 0x2002 after three wait cycles.
    pin(5, 3, 32'h0000_BEEF); pin(5, 5, 32'h1); pin(5, 4, 32'h0);
    run_op(1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 4, 1'b0, 0);

    // Store must not disturb load_data.
    run_op(1'b0, 3'b001, 32'h0000_8002, 32'h1234_5678, 32'h0, 2, 1'b0, 0);

    // Misaligned LW.
    pin(1, 5, 32'h1); pin(1, 4, 32'h1); pin(1, 6, 32'h0);
    run_op(1'b1, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1, 1'b0, 0);

    // LW with no ack: timeout.
    pin(5, 5, 32'h1); pin(5, 4, 32'h3);
    run_op(1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 1'b0, 0);

    // SW with bus error.
    pin(3, 4, 32'h2);
    run_op(1'b0, 3'b010, 32'h0000_5008, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 0);

    // Reset during ACCESS, then late ack.
    pin(3, 6, 32'h0); pin(3, 5, 32'h0);
    run_op(1'b0, 3'b010, 32'h0000_6000, 32'h0BAD_0BAD, 32'h0, 0, 1'b0, 2);

    // Load widths and lanes.
    pin(2, 3, 32'h0000_0033);
    run_op(1'b1, 3'b000, 32'h0000_7001, 32'h0, 32'h1122_3344, 1, 1'b0, 0);
    run_op(1'b1, 3'b100, 32'h0000_7003, 32'h0, 32'hAABB_CCDD, 1, 1'b0, 0);
    run_op(1'b1, 3'b001, 32'h0000_7000, 32'h0, 32'h1122_3344, 3, 1'b0, 0);
    pin(3, 3, 32'hDEAD_BEEF);
    run_op(1'b1, 3'b010, 32'h0000_7004, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 0);
    run_op(1'b0, 3'b000, 32'h0000_8001, 32'h0000_017F, 32'h0, 4, 1'b0, 0);

    // Illegal encodings and misaligned half.
    run_op(1'b0, 3'b100, 32'h0000_9000, 32'h0, 32'h0, 1, 1'b0, 0);
    run_op(1'b1, 3'b011, 32'h0000_9000, 32'h0, 32'h0, 1, 1'b0, 0);
    run_op(1'b1, 3'b001, 32'h0000_9001, 32'h0, 32'h0, 1, 1'b0, 0);

    // Start with both or neither direction set is ignored.
    tick();
    start = 1'b1; is_load = 1'b1; is_store = 1'b1;
    set_exp_idle();
    tick();
    start = 1'b1; is_load = 1'b0; is_store = 1'b0;
    set_exp_idle();
    tick();
    quiet();
    set_exp_idle();
    tick();
    set_exp_idle();

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
